// File: rtl/wib_pkg.sv
// wib_pkg: shared WIB geometry constants and fetch FSM state encoding.
// Imported by the WIB fetch sequencer and its output FIFO.
package wib_pkg;

  localparam int WIB_ADDR_W = 10;
  localparam int WIB_DATA_W = 19;
  localparam int WIB_WORDS  = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/wib_fetch_fifo.sv
// wib_fetch_fifo: synchronous FIFO, registered output, no fall-through.
// Ports: clk_i/rst_i, wr_en_i/wr_data_i push, rd_en_i pop,
// rd_data_o head word, count_o occupancy, empty_o.
module wib_fetch_fifo
  import wib_pkg::*;
#(
  parameter int W     = WIB_DATA_W + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic          wr_ok;
  logic          rd_ok;

  assign rd_ok = rd_en_i & (cnt_q != '0);
  // A push into a full FIFO is only taken alongside a pop.
  assign wr_ok = wr_en_i & ((cnt_q != FULL_C) | rd_ok);

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;
  assign empty_o   = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem_q[wptr_q] <= wr_data_i;
        wptr_q        <= wptr_q + PTR_ONE;
      end
      if (rd_ok) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wib_fetch.sv
// wib_fetch: WIB read sequencer; walks base+k*stride and turns the
// fixed-latency read data into a credit-limited valid/ready stream.
// Ports: i_clk/i_rst; command i_start, i_base_addr, i_stride, i_len;
// status o_busy, o_done; buffer o_wib_raddr, o_wib_rd_en, i_wib_rdat;
// stream o_dat, o_dat_vld, o_dat_last, i_dat_rdy.
module wib_fetch
  import wib_pkg::*;
#(
  parameter int ADDR_W     = WIB_ADDR_W,
  parameter int DATA_W     = WIB_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_stride,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_wib_raddr,
  output logic              o_wib_rd_en,
  input  logic [DATA_W-1:0] i_wib_rdat,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_dat_vld,
  output logic              o_dat_last,
  input  logic              i_dat_rdy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] stride_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_d;
  logic [ADDR_W:0]   iss_q;
  logic [ADDR_W:0]   iss_d;
  logic [RD_LAT-1:0] vsr_q;
  logic [RD_LAT-1:0] vsr_d;
  logic [RD_LAT-1:0] lsr_q;
  logic [RD_LAT-1:0] lsr_d;
  logic              done_q;
  logic              done_d;

  logic [CW-1:0]     infl;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     f_count;
  logic              f_empty;
  logic [DATA_W:0]   f_rdata;
  logic              credit;
  logic              issue;
  logic              last_iss;
  logic              pop;

  // Reads still in the buffer pipeline, not yet in the FIFO.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      infl = infl + CW'(vsr_q[i]);
    end
  end

  // Every in-flight read already owns a FIFO slot, so the FIFO
  // can never overflow whatever the downstream ready does.
  assign occ      = f_count + infl;
  assign credit   = (occ < DEPTH_C);
  assign issue    = (state_q == ST_RUN) & credit;
  assign last_iss = (iss_q == (len_q - ONE_L));
  assign pop      = ~f_empty & i_dat_rdy;

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_wib_rd_en = issue;
  assign o_wib_raddr = addr_q;
  assign o_dat       = f_rdata[DATA_W-1:0];
  assign o_dat_vld   = ~f_empty;
  assign o_dat_last  = ~f_empty & f_rdata[DATA_W];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    iss_d    = iss_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            state_d  = ST_RUN;
            addr_d   = i_base_addr;
            stride_d = i_stride;
            len_d    = i_len;
            iss_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = addr_q + stride_q;
          iss_d  = iss_q + ONE_L;
          if (last_iss) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop & o_dat_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return tracker: valid and last ride alongside the buffer latency.
  always_comb begin
    vsr_d    = '0;
    lsr_d    = '0;
    vsr_d[0] = issue;
    lsr_d[0] = issue & last_iss;
    for (int i = 1; i < RD_LAT; i++) begin
      vsr_d[i] = vsr_q[i-1];
      lsr_d[i] = lsr_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      iss_q    <= '0;
      vsr_q    <= '0;
      lsr_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      iss_q    <= iss_d;
      vsr_q    <= vsr_d;
      lsr_q    <= lsr_d;
      done_q   <= done_d;
    end
  end

  wib_fetch_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_en_i   (vsr_q[RD_LAT-1]),
    .wr_data_i ({lsr_q[RD_LAT-1], i_wib_rdat}),
    .rd_en_i   (pop),
    .rd_data_o (f_rdata),
    .count_o   (f_count),
    .empty_o   (f_empty)
  );

endmodule

// File: doc/wib_fetch.md
# wib_fetch

Read-side sequencer for the weight/input buffer (WIB). It walks a programmed address range on the buffer's NPU read port (raddr/rd_en, 19-bit data) and turns the fixed-latency read data into a valid/ready word stream for the NPU compute datapath. Reads are credit-limited against an internal output FIFO, so downstream backpressure never drops a word. The AXI BRAM-controller write side of the buffer is outside this block.

## Interface
- ADDR_W, 10, WIB word address width (1024 words)
- DATA_W, 19, WIB word width
- RD_LAT, 1, buffer read latency in cycles (1 = unregistered RAM output, 2 = registered output); legal values 1 and 2
- FIFO_DEPTH, 4, output FIFO depth; power of two, must be ≥ RD_LAT+2
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_start  in  1  one-cycle command pulse; ignored while o_busy=1
- i_base_addr  in  ADDR_W  first word address
- i_stride  in  ADDR_W  address increment per word
- i_len  in  ADDR_W+1  word count, 0..1024
- o_busy  out  1  command in progress
- o_done  out  1  one-cycle completion pulse
- o_wib_raddr  out  ADDR_W  buffer read address
- o_wib_rd_en  out  1  buffer read enable
- i_wib_rdat  in  DATA_W  buffer read data, valid RD_LAT cycles after o_wib_rd_en
- o_dat  out  DATA_W  stream data
- o_dat_vld  out  1  stream valid
- o_dat_last  out  1  marks the final word of the command
- i_dat_rdy  in  1  stream ready

## Operation
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE → RUN when i_start=1 and i_len≠0. On that edge, latch base, stride and len, and clear the issue and deliver counters.
- IDLE with i_start=1 and i_len=0: pulse o_done on the next cycle, issue no reads, stay in IDLE.
- RUN: issue one read per cycle while credit is available. Credit exists when fifo_count + inflight + (write this cycle ? 0 : 0) < FIFO_DEPTH, where inflight = number of reads issued but not yet returned (0..RD_LAT).
- Read address = (base + k·stride) mod 2^ADDR_W for k = 0..len-1. The address wraps silently; stride 0 re-reads the same word.
- After issuing read len-1: RUN → DRAIN.
- DRAIN → IDLE on the handshake (o_dat_vld & i_dat_rdy) of the word with o_dat_last=1. o_done pulses on the following cycle.
- Return capture uses an RD_LAT-deep valid/last shift register fed by o_wib_rd_en. i_wib_rdat is written into the FIFO when the shift-register tail is 1. The last flag travels with the data.
- The FIFO is a registered output with no fall-through. A write and a read in the same cycle are both legal when the FIFO is neither empty nor full.
- i_start while o_busy=1 is ignored, with no side effects.
- i_rst at any time returns the FSM to IDLE, empties the FIFO, clears the counters, and clears the in-flight shift register. Stale returns are dropped.

## Timing
- Reset values: o_busy, o_done, o_wib_rd_en, o_dat_vld and o_dat_last are 0. o_wib_raddr and o_dat are 0.
- The start edge is cycle 0. o_busy=1 and the first o_wib_rd_en are at cycle 1.
- With RD_LAT=1, the first o_dat_vld is at cycle 3; with RD_LAT=2, it is at cycle 4.
- With i_dat_rdy held at 1, throughput is one word per cycle with no bubbles for both RD_LAT values.
- o_wib_raddr is held when o_wib_rd_en=0.
- o_dat, o_dat_vld and o_dat_last are stable while o_dat_vld=1 and i_dat_rdy=0.
- o_busy falls in the same cycle that o_done pulses.

## Structure
- Shared package wib_pkg holds WIB_ADDR_W=10, WIB_DATA_W=19, WIB_WORDS=1024, and the FSM state encoding (IDLE/RUN/DRAIN).
- One sub-module, wib_fetch_fifo: a synchronous FIFO {last, data} with count output. It is parameterised on width and depth.
- The top level contains the FSM, address generator, credit counter and latency shift register; target size is about 200 lines.

## Test plan
- Basic read, RD_LAT=1, base=0x010, stride=1, len=4, i_dat_rdy=1:
  - rd_en at cycles 1–4 with addresses 0x010–0x013.
  - o_dat_vld at cycles 3–6, with o_dat_last at cycle 6.
  - o_done at cycle 7.
- Address wrap: base=0x3FE, stride=1, len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001, and the data matches the preloaded RAM.
- Backpressure: len=16, i_dat_rdy=0 for cycles 0–12, then 1.
  - At most FIFO_DEPTH reads are outstanding and the FIFO never overflows.
  - All 16 words arrive in order, with no drops or duplicates.
  - o_dat_last appears only on word 15.
- Zero length: i_len=0 → o_done at cycle 1, no o_wib_rd_en, and o_busy stays 0.
- Registered buffer: RD_LAT=2, stride=2, len=8, i_dat_rdy=1.
  - Addresses are base, base+2, … base+14.
  - 8 consecutive valid cycles with no gaps, starting at cycle 4.
- Reset mid-run: assert i_rst for 1 cycle after word 5 of a len=16 command.
  - The next cycle shows all outputs at reset values, with no late o_dat_vld from in-flight reads.
  - A fresh len=2 command then completes correctly.
